// File: rtl/vga_scan_gen.sv
// rtl/vga_scan_gen.sv - VGA pixel scan generator with overlay-latency alignment
//
// Generates the raster coordinates consumed by the overlay renderers and
// drives the VGA pins from their 1-bit pixel result. Syncs and blanking are
// delayed by OVL_LAT clks so colour lands on the pixel it belongs to.
//
// Optional feature macro: VGA_BORDER_EN (forces the outermost visible ring
// of pixels to 8'hFF).
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   col_addr_sig [10:0]   horizontal counter, 0..H_TOTAL-1
//   row_addr_sig [10:0]   vertical counter, 0..V_TOTAL-1
//   pix_en                one-clk strobe per pixel period
//   frame_start           one-clk pulse when the counters load (0,0)
//   overlay_c             OR of overlay bits, OVL_LAT clks after coordinates
//   fg_rgb / bg_rgb [7:0] RGB332 colour for overlay_c = 1 / 0
//   vga_r/g/b             colour pins (3/3/2 bits)
//   vga_hs, vga_vs        active-low syncs
module vga_scan_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int PIX_DIV  = 2,
   parameter int OVL_LAT  = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [10:0] col_addr_sig,
   output logic [10:0] row_addr_sig,
   output logic        pix_en,
   output logic        frame_start,
   input  logic        overlay_c,
   input  logic [7:0]  fg_rgb,
   input  logic [7:0]  bg_rgb,
   output logic [2:0]  vga_r,
   output logic [2:0]  vga_g,
   output logic [1:0]  vga_b,
   output logic        vga_hs,
   output logic        vga_vs
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
   localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

   localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

   // Delay-line word: bit0 hs, bit1 vs, bit2 active, bit3 border (optional).
`ifdef VGA_BORDER_EN
   localparam int DW = 4;
`else
   localparam int DW = 3;
`endif
   localparam logic [DW-1:0] DLY_RST = DW'(3);   // hs=1, vs=1, inactive

   logic [DIV_W-1:0] div_q, div_d;
   logic             pix_en_q;
   logic [10:0]      col_q, col_d;
   logic [10:0]      row_q, row_d;
   logic             fs_q, fs_d;
   logic [DW-1:0]    dly_q [OVL_LAT];
   logic [DW-1:0]    dly_in, dly_out;
   logic             hs_q, vs_q;
   logic [7:0]       rgb_q, rgb_d;
   logic             hs_raw, vs_raw, act_raw;

   always_comb begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
      col_d = col_q;
      row_d = row_q;
      fs_d  = 1'b0;
      if (pix_en_q) begin
         if (col_q == H_LAST) begin
            col_d = '0;
            if (row_q == V_LAST) begin
               row_d = '0;
               fs_d  = 1'b1;   // pulse coincides with the (0,0) load
            end else begin
               row_d = row_q + 11'd1;
            end
         end else begin
            col_d = col_q + 11'd1;
         end
      end
   end

   assign hs_raw  = !((col_q >= HS_BEG) && (col_q < HS_END));
   assign vs_raw  = !((row_q >= VS_BEG) && (row_q < VS_END));
   assign act_raw = (col_q < H_ACT) && (row_q < V_ACT);

`ifdef VGA_BORDER_EN
   logic brd_raw;
   assign brd_raw = act_raw && ((col_q == 11'd0) || (col_q == H_ACT - 11'd1) ||
                                (row_q == 11'd0) || (row_q == V_ACT - 11'd1));
   assign dly_in  = {brd_raw, act_raw, vs_raw, hs_raw};
`else
   assign dly_in  = {act_raw, vs_raw, hs_raw};
`endif

   assign dly_out = dly_q[OVL_LAT-1];

   always_comb begin
      rgb_d = 8'h00;
      if (dly_out[2]) begin
         rgb_d = overlay_c ? fg_rgb : bg_rgb;
`ifdef VGA_BORDER_EN
         if (dly_out[3]) begin
            rgb_d = 8'hFF;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q    <= '0;
         pix_en_q <= 1'b0;
         col_q    <= '0;
         row_q    <= '0;
         fs_q     <= 1'b0;
         hs_q     <= 1'b1;
         vs_q     <= 1'b1;
         rgb_q    <= 8'h00;
         for (int i = 0; i < OVL_LAT; i++) begin
            dly_q[i] <= DLY_RST;
         end
      end else begin
         div_q    <= div_d;
         pix_en_q <= (div_q == DIV_LAST);
         col_q    <= col_d;
         row_q    <= row_d;
         fs_q     <= fs_d;
         hs_q     <= dly_out[0];
         vs_q     <= dly_out[1];
         rgb_q    <= rgb_d;
         dly_q[0] <= dly_in;
         for (int i = 1; i < OVL_LAT; i++) begin
            dly_q[i] <= dly_q[i-1];
         end
      end
   end

   assign col_addr_sig = col_q;
   assign row_addr_sig = row_q;
   assign pix_en       = pix_en_q;
   assign frame_start  = fs_q;
   assign vga_hs       = hs_q;
   assign vga_vs       = vs_q;
   assign vga_r        = rgb_q[7:5];
   assign vga_g        = rgb_q[4:2];
   assign vga_b        = rgb_q[1:0];

endmodule
